i2c_slave: RTL and testbench

- 7-bit-address, 8-bit-data I2C responder; the target-side counterpart of the team's i2c master controller.
- Oversamples SCL/SDA on system clock clk0, detects START/STOP, matches its own address and ACKs it.
- Receives write bytes and sends read bytes through a simple byte handshake to local logic.
- Drives the bus open-drain only: outputs are pull-low enables.

---
 rtl/i2c_slave.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit-address / 8-bit-data I2C target. START/STOP/bit events act
//   SYNC_STAGES+1 clk0 after a pin change. The bus is driven open-drain only.
//   Local logic supplies read bytes on o_tx_req pulses and sees write bytes on o_rx_valid.
//   If no read byte is ready at a load: 0xFF is sent and tx_underrun is set, or, with
//   I2C_SLAVE_CLK_STRETCH_EN defined, SCL is held low until i_tx_valid rises.
// Ports: clk0, reset_n (async, active-low); i_scl/i_sda pin levels;
//   o_sda_low/o_scl_low pull-low enables; i_tx_data/i_tx_valid read-byte source;
//   o_tx_req next-byte request pulse; o_rx_data/o_rx_valid received write byte;
//   o_status = {busy, rw, tx_underrun, nack_seen}, sticky until the next address match.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk0,
  input  logic       reset_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_low,
  output logic       o_scl_low,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic [3:0] o_status
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  // Synchronisers reset to the idle bus level so that reset release makes no false event.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign start_ev = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_ev  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;   // 8 data bits seen; the next fall ends the byte
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d, rw_q, rw_d, und_q, und_d, nack_q, nack_d;
  logic       ack_q, ack_d;               // master ACKed the byte just sent
  logic       do_load;
  logic [7:0] tx_byte;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic       scl_low_q, scl_low_d;
  logic       stretch_q, stretch_d;       // waiting on i_tx_valid with SCL held
  logic [1:0] rel_cnt_q, rel_cnt_d;       // SDA setup delay before releasing SCL
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    sda_low_d   = sda_low_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;
    rw_d        = rw_q;
    und_d       = und_q;
    nack_d      = nack_q;
    ack_d       = ack_q;
    do_load     = 1'b0;
    tx_byte     = 8'hFF;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    scl_low_d   = scl_low_q;
    stretch_d   = stretch_q;
    rel_cnt_d   = rel_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d    = 1'b0;
        sda_low_d = 1'b0;
      end
      ADDR, RX_DATA: begin
        if (scl_rise) begin
          rx_sh_d   = {rx_sh_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
        end else if (scl_fall && byte_done_q) begin
          byte_done_d = 1'b0;
          if (state_q == RX_DATA) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            sda_low_d  = 1'b1;
            state_d    = RX_ACK;
          end else if (rx_sh_q[7:1] == SLAVE_ADDR) begin
            rw_d      = rx_sh_q[0];
            busy_d    = 1'b1;
            und_d     = 1'b0;
            nack_d    = 1'b0;
            sda_low_d = 1'b1;
            state_d   = ADDR_ACK;
          end else begin
            sda_low_d = 1'b0;
            state_d   = WAIT_STOP;
          end
        end
      end
      ADDR_ACK: begin
        if (scl_rise && rw_q) begin
          tx_req_d = 1'b1;
        end else if (scl_fall) begin
          if (rw_q) begin
            do_load = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            state_d   = RX_DATA;
          end
        end
      end
      RX_ACK: begin
        if (scl_fall) begin
          sda_low_d = 1'b0;
          state_d   = RX_DATA;
        end
      end
      TX_DATA: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
        end else if (scl_fall) begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            sda_low_d   = 1'b0;
            state_d     = TX_ACK;
          end else begin
            sda_low_d = ~tx_sh_q[7];
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      TX_ACK: begin
        if (scl_rise) begin
          if (!sda_s) begin
            ack_d    = 1'b1;
            tx_req_d = 1'b1;
          end else begin
            ack_d  = 1'b0;
            nack_d = 1'b1;
          end
        end else if (scl_fall) begin
          if (ack_q) begin
            do_load = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            state_d   = WAIT_STOP;
          end
        end
      end
      WAIT_STOP: sda_low_d = 1'b0;
      default:   state_d   = IDLE;
    endcase

    // Loading a read byte: the shifter keeps the bits still to go, MSB goes straight to the pin.
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    if (rel_cnt_q != 2'd0) begin
      rel_cnt_d = rel_cnt_q - 2'd1;
      if (rel_cnt_q == 2'd1) scl_low_d = 1'b0;
    end
    if (do_load && !i_tx_valid) begin
      scl_low_d = 1'b1;
      stretch_d = 1'b1;
    end else if (do_load || (stretch_q && i_tx_valid)) begin
      tx_byte     = i_tx_data;
      sda_low_d   = ~tx_byte[7];
      tx_sh_d     = {tx_byte[6:0], 1'b0};
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      state_d     = TX_DATA;
      if (stretch_q) begin
        stretch_d = 1'b0;
        rel_cnt_d = 2'd2;
      end
    end
`else
    if (do_load) begin
      tx_byte     = i_tx_valid ? i_tx_data : 8'hFF;
      und_d       = und_q | ~i_tx_valid;
      sda_low_d   = ~tx_byte[7];
      tx_sh_d     = {tx_byte[6:0], 1'b0};
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      state_d     = TX_DATA;
    end
`endif

    // Bus conditions override whatever the current state decided.
    if (start_ev || stop_ev) begin
      sda_low_d   = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      state_d     = start_ev ? ADDR : IDLE;
      if (stop_ev) busy_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_low_d   = 1'b0;
      stretch_d   = 1'b0;
      rel_cnt_d   = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rx_sh_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      sda_low_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      und_q       <= 1'b0;
      nack_q      <= 1'b0;
      ack_q       <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_low_q   <= 1'b0;
      stretch_q   <= 1'b0;
      rel_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      sda_low_q   <= sda_low_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      und_q       <= und_d;
      nack_q      <= nack_d;
      ack_q       <= ack_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_low_q   <= scl_low_d;
      stretch_q   <= stretch_d;
      rel_cnt_q   <= rel_cnt_d;
`endif
    end
  end

  assign o_sda_low  = sda_low_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign o_scl_low  = scl_low_q;
`else
  assign o_scl_low  = 1'b0;
`endif
  assign o_tx_req   = tx_req_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_status   = {busy_q, rw_q, und_q, nack_q};

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master drives an open-drain bus model, a local
// responder answers o_tx_req, and a transaction-level model (expected byte queues and
// status flags) is checked against the DUT.
module tb_i2c_slave;
  localparam int H = 12;   // clk0 cycles per SCL half period

  logic       clk0 = 1'b0;
  logic       reset_n;
  logic       m_scl_low, m_sda_low;
  logic       scl_bus, sda_bus;
  logic       o_sda_low, o_scl_low, o_tx_req, o_rx_valid;
  logic [7:0] o_rx_data, i_tx_data;
  logic       i_tx_valid;
  logic [3:0] o_status;

  always #5 clk0 = ~clk0;

  assign scl_bus = ~(m_scl_low | o_scl_low);
  assign sda_bus = ~(m_sda_low | o_sda_low);

  i2c_slave dut (
    .clk0(clk0), .reset_n(reset_n), .i_scl(scl_bus), .i_sda(sda_bus),
    .o_sda_low(o_sda_low), .o_scl_low(o_scl_low),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_req(o_tx_req),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_status(o_status)
  );

  int checks = 0;
  int failures = 0;

  // Model state: bytes the slave must deliver/send, and the status it must report.
  logic [7:0] exp_rx[$];
  logic [8:0] exp_tx[$];   // {underrun, byte} in the order the bus must carry them
  logic [7:0] tx_src[$];   // bytes local logic has ready for reads
  logic mdl_addressed = 1'b0;
  logic mdl_busy = 1'b0, mdl_rw = 1'b0, mdl_und = 1'b0, mdl_nack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of the outputs against the model.
  always @(negedge clk0) begin
    if (o_rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected", 32'(o_rx_valid), 32'd0);
      else                    check("rx_data", 32'(o_rx_data), 32'(exp_rx.pop_front()));
    end
    if (!mdl_addressed) check("sda_quiet", 32'(o_sda_low), 32'd0);
`ifndef I2C_SLAVE_CLK_STRETCH_EN
    check("scl_released", 32'(o_scl_low), 32'd0);
`endif
  end

  // Local responder: supplies the next queued byte on each request.
  initial begin
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    forever begin
      @(negedge clk0);
      if (o_tx_req) begin
        if (tx_src.size() > 0) begin
          i_tx_data  = tx_src.pop_front();
          i_tx_valid = 1'b1;
          exp_tx.push_back({1'b0, i_tx_data});
        end else begin
          i_tx_valid = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          exp_tx.push_back({1'b0, 8'h77});
          fork
            begin
              repeat (40) @(negedge clk0);
              i_tx_data  = 8'h77;
              i_tx_valid = 1'b1;
            end
          join_none
`else
          exp_tx.push_back({1'b1, 8'hFF});
`endif
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk0);
  endtask

  task automatic scl_release();
    int t = 0;
    m_scl_low = 1'b0;
    while (scl_bus !== 1'b1 && t < 5000) begin
      @(negedge clk0);
      t++;
    end
    if (t >= 5000) check("scl_stuck_low", 32'(scl_bus), 32'd1);
  endtask

  // One SCL clock, entered and left with SCL low. drv=1 releases SDA.
  task automatic clk_bit(input logic drv, output logic smp);
    wait_n(H/2);
    m_sda_low = ~drv;
    wait_n(H/2);
    scl_release();
    wait_n(H/2);
    smp = sda_bus;
    wait_n(H/2);
    m_scl_low = 1'b1;
  endtask

  task automatic do_start();
    if (m_scl_low) begin
      wait_n(H/2);
      mdl_addressed = 1'b0;
      m_sda_low = 1'b0;
      wait_n(H/2);
      scl_release();
    end
    wait_n(H/2);
    m_sda_low = 1'b1;
    wait_n(H/2);
    m_scl_low = 1'b1;
  endtask

  task automatic do_stop();
    wait_n(H/2);
    m_sda_low = 1'b1;
    wait_n(H/2);
    scl_release();
    wait_n(H/2);
    m_sda_low = 1'b0;
    wait_n(H);
    mdl_addressed = 1'b0;
    mdl_busy = 1'b0;
    check("stop_status", 32'(o_status), 32'({mdl_busy, mdl_rw, mdl_und, mdl_nack}));
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic matched);
    logic [7:0] b;
    logic s;
    b = {a, rw};
    matched = (a == 7'h50);
    mdl_addressed = matched;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    if (matched) begin
      mdl_busy = 1'b1; mdl_rw = rw; mdl_und = 1'b0; mdl_nack = 1'b0;
    end
    clk_bit(1'b1, s);
    check("addr_ack", 32'(s), matched ? 32'd0 : 32'd1);
    if (matched) begin
      @(negedge clk0);
      check("addr_status", 32'({o_status[3:2], o_status[0]}), 32'({1'b1, rw, 1'b0}));
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic matched);
    logic s;
    if (matched) exp_rx.push_back(b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    check("data_ack", 32'(s), matched ? 32'd0 : 32'd1);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] got);
    logic s;
    logic [8:0] e;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      got[i] = s;
    end
    if (exp_tx.size() == 0) begin
      check("tx_req_missing", 32'(got), 32'h100);
    end else begin
      e = exp_tx.pop_front();
      if (e[8]) mdl_und = 1'b1;
      check("rd_byte", 32'(got), 32'(e[7:0]));
    end
    check("rd_status", 32'(o_status), 32'({mdl_busy, mdl_rw, mdl_und, mdl_nack}));
    clk_bit(~ack, s);
    if (!ack) mdl_nack = 1'b1;
  endtask

  initial begin
    logic m;
    logic s;
    logic [7:0] got;
    int n, nsrc;
    logic [6:0] a;
    logic rw;

    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    reset_n   = 1'b0;
    wait_n(5);
    check("rst_sda_low", 32'(o_sda_low), 32'd0);
    check("rst_scl_low", 32'(o_scl_low), 32'd0);
    check("rst_status",  32'(o_status),  32'd0);
    check("rst_rx_data", 32'(o_rx_data), 32'd0);
    check("rst_pulses",  32'({o_tx_req, o_rx_valid}), 32'd0);
    reset_n = 1'b1;
    wait_n(H);

    // Write 0x3C, 0xC3.
    do_start();
    send_addr(7'h50, 1'b0, m);
    wr_byte(8'h3C, m);
    wr_byte(8'hC3, m);
    do_stop();
    check("wr_last_rx", 32'(o_rx_data), 32'hC3);
    check("wr_status_lit", 32'(o_status), 32'h0);

    // Read 0x5A (ACK) then 0x96 (NACK).
    tx_src.push_back(8'h5A);
    tx_src.push_back(8'h96);
    do_start();
    send_addr(7'h50, 1'b1, m);
    rd_byte(1'b1, got);
    check("rd_bits1_lit", 32'(got), 32'b01011010);
    rd_byte(1'b0, got);
    check("rd_bits2_lit", 32'(got), 32'b10010110);
    do_stop();
    check("rd_status_lit", 32'(o_status), 32'b0101);

    // Address mismatch, then a matching START without STOP in between.
    do_start();
    send_addr(7'h51, 1'b0, m);
    do_start();
    send_addr(7'h50, 1'b0, m);
    wr_byte(8'h5C, m);
    do_stop();

    // Repeated start: write 0x10, Sr, read one byte.
    tx_src.push_back(8'hE7);
    do_start();
    send_addr(7'h50, 1'b0, m);
    wr_byte(8'h10, m);
    do_start();
    send_addr(7'h50, 1'b1, m);
    rd_byte(1'b0, got);
    do_stop();
    check("sr_rx_lit", 32'(o_rx_data), 32'h10);
    check("sr_status_lit", 32'(o_status), 32'b0101);

    // Read with nothing ready.
    do_start();
    send_addr(7'h50, 1'b1, m);
    rd_byte(1'b0, got);
    do_stop();
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    check("und_byte_lit", 32'(got), 32'h77);
    check("und_status_lit", 32'(o_status), 32'b0101);
`else
    check("und_byte_lit", 32'(got), 32'hFF);
    check("und_status_lit", 32'(o_status), 32'b0111);
`endif

    // STOP after 3 bits of a data byte.
    do_start();
    send_addr(7'h50, 1'b0, m);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    do_stop();

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      rw = 1'($urandom);
      n  = $urandom_range(1, 3);
      nsrc = ($urandom_range(0, 3) == 0) ? n - 1 : n;
      if (rw && a == 7'h50)
        for (int i = 0; i < nsrc; i++) tx_src.push_back(8'($urandom));
      do_start();
      send_addr(a, rw, m);
      if (m && rw) begin
        for (int i = 0; i < n; i++) rd_byte(i != n - 1, got);
      end else begin
        for (int i = 0; i < n; i++) wr_byte(8'($urandom), m);
      end
      do_stop();
    end

    // Reset in the middle of a read byte 0x00 (slave pulling SDA low).
    tx_src.push_back(8'h00);
    do_start();
    send_addr(7'h50, 1'b1, m);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    check("pre_rst_sda_low", 32'(o_sda_low), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sda_low", 32'(o_sda_low), 32'd0);
    check("mid_rst_status", 32'(o_status), 32'd0);
    check("mid_rst_rx_data", 32'(o_rx_data), 32'd0);
    mdl_addressed = 1'b0;
    mdl_busy = 1'b0; mdl_rw = 1'b0; mdl_und = 1'b0; mdl_nack = 1'b0;
    exp_tx.delete();
    wait_n(3);
    reset_n = 1'b1;
    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    wait_n(H);
    do_start();
    send_addr(7'h50, 1'b0, m);
    wr_byte(8'hA5, m);
    do_stop();

    wait_n(H);
    check("rx_leftover", 32'(exp_rx.size()), 32'd0);
    check("tx_leftover", 32'(exp_tx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
